coverfloat_txn_arbiter: RTL

//  Shares one coverfloat transaction port (op/rm/enableBits/a/b/c/fmts/result/exceptionBits)

---
 rtl/coverfloat_txn_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/coverfloat_txn_arbiter.sv
// rtl/coverfloat_txn_arbiter.sv - round-robin arbiter sharing one coverfloat transaction port
// Optional per-requester grant statistics: define COVERFLOAT_ARB_STATS_EN.
module coverfloat_txn_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TXN_W   = 652,
  parameter int MIN_GAP = 0,
  localparam int GW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*TXN_W-1:0]   req_txn,
  input  logic                     cf_stall,
  output logic                     cf_valid,
  output logic [31:0]              cf_op,
  output logic [31:0]              cf_rm,
  output logic [31:0]              cf_enableBits,
  output logic [127:0]             cf_a,
  output logic [127:0]             cf_b,
  output logic [127:0]             cf_c,
  output logic [2:0]               cf_aFmt,
  output logic [2:0]               cf_bFmt,
  output logic [2:0]               cf_cFmt,
  output logic [127:0]             cf_result,
  output logic [2:0]               cf_resultFmt,
  output logic [31:0]              cf_exceptionBits,
  output logic [GW-1:0]            grant_id,
  output logic [31:0]              issue_count
`ifdef COVERFLOAT_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]      stat_grants
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t           state, stateNext;
  logic [3:0]       gapCnt, gapCntNext;
  logic [TXN_W-1:0] txnReg;
  logic [GW-1:0]    grantReg;
  logic [GW-1:0]    lastGrant;
  logic [31:0]      issueCount;
  logic [GW-1:0]    grantIdx;
  logic             grantFound;
  logic             accept;
  int               idx;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    grantIdx   = '0;
    grantFound = 1'b0;
    idx        = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(lastGrant) + k) % N_REQ;
      if (!grantFound && req_valid[idx]) begin
        grantFound = 1'b1;
        grantIdx   = GW'(idx);
      end
    end
  end

  assign accept = ((state == IDLE) || ((state == ISSUE) && (MIN_GAP == 0)))
                  && grantFound && !cf_stall;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = accept && (grantIdx == GW'(i));
    end
  end

  always_comb begin
    stateNext  = state;
    gapCntNext = gapCnt;
    case (state)
      IDLE: begin
        if (accept) stateNext = ISSUE;
      end
      ISSUE: begin
        if (MIN_GAP > 0) begin
          stateNext  = GAP;
          gapCntNext = 4'(MIN_GAP);
        end else if (accept) begin
          stateNext = ISSUE;
        end else begin
          stateNext = IDLE;
        end
      end
      GAP: begin
        gapCntNext = gapCnt - 4'd1;
        if (gapCnt <= 4'd1) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gapCnt <= '0;
    end else begin
      state  <= stateNext;
      gapCnt <= gapCntNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txnReg    <= '0;
      grantReg  <= '0;
      lastGrant <= GW'(N_REQ - 1);
    end else if (accept) begin
      txnReg    <= req_txn[int'(grantIdx)*TXN_W +: TXN_W];
      grantReg  <= grantIdx;
      lastGrant <= grantIdx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issueCount <= '0;
    end else if (state == ISSUE) begin
      issueCount <= issueCount + 32'd1;
    end
  end

  assign cf_valid         = (state == ISSUE);
  assign grant_id         = grantReg;
  assign issue_count      = issueCount;
  assign cf_op            = txnReg[TXN_W-1   -: 32];
  assign cf_rm            = txnReg[TXN_W-33  -: 32];
  assign cf_enableBits    = txnReg[TXN_W-65  -: 32];
  assign cf_a             = txnReg[TXN_W-97  -: 128];
  assign cf_b             = txnReg[TXN_W-225 -: 128];
  assign cf_c             = txnReg[TXN_W-353 -: 128];
  assign cf_aFmt          = txnReg[TXN_W-481 -: 3];
  assign cf_bFmt          = txnReg[TXN_W-484 -: 3];
  assign cf_cFmt          = txnReg[TXN_W-487 -: 3];
  assign cf_result        = txnReg[TXN_W-490 -: 128];
  assign cf_resultFmt     = txnReg[TXN_W-618 -: 3];
  assign cf_exceptionBits = txnReg[TXN_W-621 -: 32];

`ifdef COVERFLOAT_ARB_STATS_EN
  logic [15:0] statCnt [N_REQ];

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) statCnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ready[i] && (statCnt[i] != 16'hFFFF)) statCnt[i] <= statCnt[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign stat_grants[g*16 +: 16] = statCnt[g];
  end
`endif

endmodule
